// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, ALU/mux encodings and the multi-cycle
// control state encoding. The single-cycle decoder imports the same package.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_GTZ   = 3'b110,
    ALU_SLT   = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  // Encodings are visible on the debug port, so they are fixed, not tool-chosen.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
    logic       illegal;
    logic       fault;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic is_supported(input logic [5:0] op);
    return op inside {OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW,
                      OP_BEQ, OP_BNE, OP_BGTZ, OP_J};
  endfunction

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_R:                               return S_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  return S_EXEC_I;
      OP_LW, OP_SW:                       return S_MEMADR;
      OP_BEQ, OP_BNE, OP_BGTZ:            return S_BRANCH;
      OP_J:                               return S_JUMP;
      default:                            return S_FETCH;
    endcase
  endfunction

  function automatic alu_op_t imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags the cycle whose wait would make
// the count reach TIMEOUT, so a late ready on that same cycle still wins.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: Moore state
// outputs plus Mealy gating on mem_ready and the branch condition flags.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       positive,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       fault,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   wait_en;
  logic   wait_clr;
  logic   timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Any state change clears the counter, which covers entry into each wait state.
  assign wait_en  = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !mem_ready;
  assign wait_clr = (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (timed_out)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ctrl    = CTRL_IDLE;

    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.illegal   = !is_supported(op);
        state_d        = decode_next(op);
      end

      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_RWB;
      end

      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end

      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(op);
        state_d        = S_IWB;
      end

      S_IWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end

      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end

      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end

      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.pc_source = PCSRC_ALUOUT;
        case (op)
          OP_BEQ: begin
            ctrl.alu_op   = ALU_SUB;
            ctrl.pc_write = zero;
          end
          OP_BNE: begin
            ctrl.alu_op   = ALU_SUB;
            ctrl.pc_write = !zero;
          end
          OP_BGTZ: begin
            ctrl.alu_op   = ALU_GTZ;
            ctrl.pc_write = positive;
          end
          default: ;
        endcase
        state_d = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = S_FETCH;
      end

      S_FAULT: begin
        ctrl.fault = 1'b1;
        state_d    = S_FAULT;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces FETCH, whose outputs request a read; gating here drops every
  // request the moment rst rises instead of at the next clock edge.
  assign ctrl_out = rst ? CTRL_IDLE : ctrl;

  assign pc_write   = ctrl_out.pc_write;
  assign iord       = ctrl_out.iord;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign ir_write   = ctrl_out.ir_write;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign reg_dst    = ctrl_out.reg_dst;
  assign reg_write  = ctrl_out.reg_write;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign pc_source  = ctrl_out.pc_source;
  assign illegal    = ctrl_out.illegal;
  assign fault      = ctrl_out.fault;
  assign state      = state_q;

endmodule
